int_sequencer: RTL

Interrupt and return-from-interrupt sequencer for the 5-stage RISC pipeline. It detects an external interrupt, freezes fetch and drains the pipeline, and pushes the return PC and CCR onto the stack through the data-memory port. It then loads the interrupt vector from data memory and redirects fetch. On RTI it pops CCR and PC back and resumes fetch. It sits beside the decode stage and owns the data-memory port only while a sequence is active.

---
 rtl/int_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/int_sequencer.sv
// Interrupt entry / return-from-interrupt sequencer.
// On an interrupt it freezes fetch, drains the pipeline, pushes the return
// PC (high word, then low word) and CCR through the data-memory port, fetches
// the two-word vector and redirects fetch. On RTI it pops CCR, PC low and PC
// high in that order and then resumes fetch.
//
// Handshake: the data-memory port is a request/grant pair. While mem_req is
// high the access fields (mem_we, mem_use_sp, mem_addr, mem_wdata) are held
// stable, and the access completes in the cycle mem_gnt is high. Read data is
// taken in that same cycle. mem_gnt low stalls the current access state.
module int_sequencer #(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [11:0] VEC_ADDR     = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    input  logic        pipe_hazard,
    input  logic        rti_req,
    input  logic [31:0] pc_in,
    input  logic [2:0]  ccr_in,
    output logic        ack,
    output logic        freeze,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_use_sp,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic [15:0] mem_rdata,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic        ccr_load,
    output logic [2:0]  ccr_value,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DRAIN    = 4'd1,
        PUSH_PCH = 4'd2,
        PUSH_PCL = 4'd3,
        PUSH_CCR = 4'd4,
        VEC_LO   = 4'd5,
        VEC_HI   = 4'd6,
        JUMP     = 4'd7,
        POP_CCR  = 4'd8,
        POP_PCL  = 4'd9,
        POP_PCH  = 4'd10,
        RESUME   = 4'd11
    } state_t;

    // Drain counter is loaded with DRAIN_CYCLES-1 so DRAIN lasts exactly DRAIN_CYCLES.
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t      state;
    state_t      state_n;
    logic        irq_prev;
    logic        pending;
    logic [2:0]  drain_cnt;
    logic [31:0] ret_pc;
    logic [2:0]  ret_ccr;
    logic [31:0] vec;
    logic [31:0] pop_pc;
    logic [2:0]  pop_ccr;
    logic        take;

    // RTI has priority over a takeable interrupt; the interrupt then stays pending.
    assign take      = (state == IDLE) && pending && !pipe_hazard && !rti_req;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Edge detect, pending flag, accept pulse and drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev  <= 1'b0;
            pending   <= 1'b0;
            ack       <= 1'b0;
            drain_cnt <= 3'd0;
        end else begin
            irq_prev <= irq;
            ack      <= take;
            if (take)                   pending <= 1'b0;
            else if (irq && !irq_prev)  pending <= 1'b1;
            if (take)                                  drain_cnt <= DRAIN_LOAD;
            else if (state == DRAIN && drain_cnt != 0) drain_cnt <= drain_cnt - 3'd1;
        end
    end

    // Captured return context, fetched vector and popped context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_pc  <= 32'h0;
            ret_ccr <= 3'h0;
            vec     <= 32'h0;
            pop_pc  <= 32'h0;
            pop_ccr <= 3'h0;
        end else begin
            if (take) begin
                ret_pc  <= pc_in;
                ret_ccr <= ccr_in;
            end
            if (mem_gnt) begin
                case (state)
                    VEC_LO:  vec[15:0]     <= mem_rdata;
                    VEC_HI:  vec[31:16]    <= mem_rdata;
                    POP_CCR: pop_ccr       <= mem_rdata[2:0];
                    POP_PCL: pop_pc[15:0]  <= mem_rdata;
                    POP_PCH: pop_pc[31:16] <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    // Next-state and all combinational outputs decoded from the current state.
    always_comb begin
        state_n    = state;
        freeze     = (state != IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_use_sp = 1'b0;
        mem_addr   = 12'h0;
        mem_wdata  = 16'h0;
        pc_load    = 1'b0;
        pc_value   = 32'h0;
        ccr_load   = 1'b0;
        ccr_value  = 3'h0;
        case (state)
            IDLE: begin
                if (rti_req)   state_n = POP_CCR;
                else if (take) state_n = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 3'd0) state_n = PUSH_PCH;
            end
            PUSH_PCH: begin
                mem_req = 1'b1; mem_we = 1'b1; mem_use_sp = 1'b1;
                mem_wdata = ret_pc[31:16];
                if (mem_gnt) state_n = PUSH_PCL;
            end
            PUSH_PCL: begin
                mem_req = 1'b1; mem_we = 1'b1; mem_use_sp = 1'b1;
                mem_wdata = ret_pc[15:0];
                if (mem_gnt) state_n = PUSH_CCR;
            end
            PUSH_CCR: begin
                mem_req = 1'b1; mem_we = 1'b1; mem_use_sp = 1'b1;
                mem_wdata = {13'b0, ret_ccr};
                if (mem_gnt) state_n = VEC_LO;
            end
            VEC_LO: begin
                mem_req = 1'b1;
                mem_addr = VEC_ADDR;
                if (mem_gnt) state_n = VEC_HI;
            end
            VEC_HI: begin
                mem_req = 1'b1;
                mem_addr = VEC_ADDR + 12'd1;
                if (mem_gnt) state_n = JUMP;
            end
            JUMP: begin
                pc_load  = 1'b1;
                pc_value = vec;
                state_n  = IDLE;
            end
            POP_CCR: begin
                mem_req = 1'b1; mem_use_sp = 1'b1;
                if (mem_gnt) state_n = POP_PCL;
            end
            POP_PCL: begin
                mem_req = 1'b1; mem_use_sp = 1'b1;
                if (mem_gnt) state_n = POP_PCH;
            end
            POP_PCH: begin
                mem_req = 1'b1; mem_use_sp = 1'b1;
                if (mem_gnt) state_n = RESUME;
            end
            RESUME: begin
                pc_load   = 1'b1;
                pc_value  = pop_pc;
                ccr_load  = 1'b1;
                ccr_value = pop_ccr;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
